knn_vote: RTL and testbench



---
 rtl/knn_pkg.sv | 33 +++
 rtl/knn_label_match_cnt.sv | 23 ++
 rtl/knn_vote.sv | 124 ++++++++++++
 tb/tb_knn_vote.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/knn_pkg.sv
// Shared constants, slot accessors and FSM encoding for the K-nearest-neighbour vote stage.
package knn_pkg;

    localparam int DATA_W    = 32;
    localparam int LABEL_W   = 8;
    localparam int DATA_INFO = DATA_W + LABEL_W;
    localparam int K         = 4;
    localparam int CNT_W     = $clog2(K + 1);
    localparam int IDX_W     = (K > 1) ? $clog2(K) : 1;
    localparam int LIST_W    = K * DATA_INFO;

    localparam int DIST_LSB  = 0;
    localparam int LABEL_LSB = DATA_W;

    localparam logic [DATA_W-1:0] EMPTY_DIST = {DATA_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [DATA_W-1:0] slot_dist(input logic [LIST_W-1:0] list,
                                                    input logic [IDX_W-1:0]  idx);
        return list[int'(idx) * DATA_INFO + DIST_LSB +: DATA_W];
    endfunction

    function automatic logic [LABEL_W-1:0] slot_label(input logic [LIST_W-1:0] list,
                                                      input logic [IDX_W-1:0]  idx);
        return list[int'(idx) * DATA_INFO + LABEL_LSB +: LABEL_W];
    endfunction

endpackage

// File: rtl/knn_label_match_cnt.sv
// Counts the non-empty slots of a neighbour snapshot whose label equals the candidate label.
module knn_label_match_cnt
    import knn_pkg::*;
(
    input  logic [LABEL_W-1:0] cand_label,
    input  logic [LIST_W-1:0]  snap,
    output logic [CNT_W-1:0]   match_cnt
);

    // Sum of label matches over all occupied slots
    always_comb begin
        match_cnt = {CNT_W{1'b0}};
        for (int j = 0; j < K; j++) begin
            if ((slot_dist(snap, IDX_W'(j)) != EMPTY_DIST) &&
                (slot_label(snap, IDX_W'(j)) == cand_label)) begin
                match_cnt = match_cnt + CNT_W'(1);
            end else begin
                match_cnt = match_cnt;
            end
        end
    end

endmodule

// File: rtl/knn_vote.sv
// Sequential majority vote over a snapshot of the K-nearest-neighbour list, one candidate slot per cycle.
module knn_vote
    import knn_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               vote_start,
    input  logic [LIST_W-1:0]  nb_list,
    output logic               busy,
    output logic               done,
    output logic [LABEL_W-1:0] class_label,
    output logic [CNT_W-1:0]   vote_count,
    output logic               no_valid
);

    state_t             state_r;
    logic [LIST_W-1:0]  snap_r;
    logic [CNT_W-1:0]   best_count_r;
    logic [DATA_W-1:0]  best_dist_r;
    logic [LABEL_W-1:0] best_label_r;
    logic [IDX_W-1:0]   index_r;

    logic [DATA_W-1:0]  cand_dist_s;
    logic [LABEL_W-1:0] cand_label_s;
    logic [CNT_W-1:0]   match_cnt_s;
    logic [CNT_W-1:0]   cand_cnt_s;
    logic               replace_s;
    logic [CNT_W-1:0]   nxt_count_s;
    logic [DATA_W-1:0]  nxt_dist_s;
    logic [LABEL_W-1:0] nxt_label_s;
    logic               last_s;

    knn_label_match_cnt u_match (
        .cand_label (cand_label_s),
        .snap       (snap_r),
        .match_cnt  (match_cnt_s)
    );

    // Candidate selection and best-so-far update; ties on count go to the strictly nearer slot
    always_comb begin
        cand_dist_s  = slot_dist(snap_r, index_r);
        cand_label_s = slot_label(snap_r, index_r);
        if (cand_dist_s == EMPTY_DIST) begin
            cand_cnt_s = {CNT_W{1'b0}};
        end else begin
            cand_cnt_s = match_cnt_s;
        end
        replace_s = (cand_cnt_s > best_count_r) ||
                    ((cand_cnt_s == best_count_r) && (cand_cnt_s != {CNT_W{1'b0}}) &&
                     (cand_dist_s < best_dist_r));
        if (replace_s) begin
            nxt_count_s = cand_cnt_s;
            nxt_dist_s  = cand_dist_s;
            nxt_label_s = cand_label_s;
        end else begin
            nxt_count_s = best_count_r;
            nxt_dist_s  = best_dist_r;
            nxt_label_s = best_label_r;
        end
        last_s = (index_r == IDX_W'(K - 1));
    end

    // Vote FSM with registered status and result outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            snap_r       <= {LIST_W{1'b0}};
            best_count_r <= {CNT_W{1'b0}};
            best_dist_r  <= {DATA_W{1'b0}};
            best_label_r <= {LABEL_W{1'b0}};
            index_r      <= {IDX_W{1'b0}};
            busy         <= 1'b0;
            done         <= 1'b0;
            class_label  <= {LABEL_W{1'b0}};
            vote_count   <= {CNT_W{1'b0}};
            no_valid     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (vote_start) begin
                        snap_r       <= nb_list;
                        best_count_r <= {CNT_W{1'b0}};
                        best_dist_r  <= EMPTY_DIST;
                        best_label_r <= {LABEL_W{1'b0}};
                        index_r      <= {IDX_W{1'b0}};
                        busy         <= 1'b1;
                        state_r      <= ST_SCAN;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    best_count_r <= nxt_count_s;
                    best_dist_r  <= nxt_dist_s;
                    best_label_r <= nxt_label_s;
                    if (last_s) begin
                        class_label <= nxt_label_s;
                        vote_count  <= nxt_count_s;
                        no_valid    <= (nxt_count_s == {CNT_W{1'b0}});
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state_r     <= ST_DONE;
                    end else begin
                        index_r <= index_r + IDX_W'(1);
                        state_r <= ST_SCAN;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_knn_vote.sv
// Directed bench for knn_vote: table of hand-computed votes plus multi-cycle corner sequences.
module tb_knn_vote;
    import knn_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               vote_start;
    logic [LIST_W-1:0]  nb_list;
    logic               busy;
    logic               done;
    logic [LABEL_W-1:0] class_label;
    logic [CNT_W-1:0]   vote_count;
    logic               no_valid;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] E = 32'hFFFF_FFFF;

    typedef struct {
        logic [LIST_W-1:0] list;
        logic [7:0]        lab;
        logic [2:0]        cnt;
        logic              nv;
    } vec_t;

    vec_t vecs[8];

    knn_vote dut (
        .clk         (clk),
        .rst         (rst),
        .vote_start  (vote_start),
        .nb_list     (nb_list),
        .busy        (busy),
        .done        (done),
        .class_label (class_label),
        .vote_count  (vote_count),
        .no_valid    (no_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [LIST_W-1:0] mk(input logic [7:0] l0, l1, l2, l3,
                                             input logic [31:0] d0, d1, d2, d3);
        return {l3, d3, l2, d2, l1, d1, l0, d0};
    endfunction

    task automatic run_vote(input string name, input logic [LIST_W-1:0] list,
                            input logic [7:0] el, input logic [2:0] ec, input logic env);
        int n;
        n = 0;
        nb_list    = list;
        vote_start = 1'b1;
        @(posedge clk); #1;
        vote_start = 1'b0;
        check({name, " busy"}, 32'(busy), 32'd1);
        for (int i = 1; i <= 3 * K; i++) begin
            @(posedge clk); #1;
            if (done) begin
                n = i;
                break;
            end
        end
        check({name, " latency"}, 32'(n), 32'(K));
        check({name, " label"}, 32'(class_label), 32'(el));
        check({name, " count"}, 32'(vote_count), 32'(ec));
        check({name, " no_valid"}, 32'(no_valid), 32'(env));
        check({name, " busy in done"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        check({name, " done pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int dones;
        int nd;
        int last_done;
        logic prev_done;
        logic [LIST_W-1:0] b2b_list[3];
        logic [7:0]        b2b_lab[3];
        logic [2:0]        b2b_cnt[3];

        rst        = 1'b0;
        vote_start = 1'b0;
        nb_list    = {LIST_W{1'b0}};
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset label", 32'(class_label), 32'd0);
        check("reset count", 32'(vote_count), 32'd0);
        check("reset no_valid", 32'(no_valid), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        vecs[0] = '{mk(8'd3, 8'd3, 8'd7, 8'd9, 32'd5, 32'd10, 32'd2, 32'd20), 8'd3, 3'd2, 1'b0};
        vecs[1] = '{mk(8'd1, 8'd2, 8'd1, 8'd2, 32'd8, 32'd4, 32'd9, 32'd6), 8'd2, 3'd2, 1'b0};
        vecs[2] = '{mk(8'd1, 8'd2, 8'd1, 8'd2, 32'd5, 32'd5, 32'd5, 32'd5), 8'd1, 3'd2, 1'b0};
        vecs[3] = '{mk(8'd5, 8'd5, 8'd5, 8'd5, 32'd7, E, E, E), 8'd5, 3'd1, 1'b0};
        vecs[4] = '{mk(8'd4, 8'd4, 8'd4, 8'd4, E, E, E, E), 8'd0, 3'd0, 1'b1};
        vecs[5] = '{mk(8'd6, 8'd6, 8'd6, 8'd2, 32'd30, 32'd20, 32'd10, 32'd1), 8'd6, 3'd3, 1'b0};
        vecs[6] = '{mk(8'd10, 8'd11, 8'd12, 8'd13, 32'd9, 32'd3, 32'd7, 32'd3), 8'd11, 3'd1, 1'b0};
        vecs[7] = '{mk(8'd200, 8'd200, 8'd200, 8'd200, 32'd1, 32'd2, 32'd3, 32'd4), 8'd200, 3'd4, 1'b0};

        for (int v = 0; v < 8; v++) begin
            run_vote($sformatf("vec%0d", v), vecs[v].list, vecs[v].lab, vecs[v].cnt, vecs[v].nv);
        end

        // Start held high and nb_list changed while scanning
        nb_list    = vecs[0].list;
        vote_start = 1'b1;
        @(posedge clk); #1;
        nb_list = vecs[4].list;
        dones   = 0;
        for (int i = 1; i <= K + 6; i++) begin
            @(posedge clk); #1;
            if (i == 2) nb_list = vecs[7].list;
            if (done) begin
                dones++;
                check("ignored start label", 32'(class_label), 32'd3);
                check("ignored start count", 32'(vote_count), 32'd2);
                vote_start = 1'b0;
            end
        end
        vote_start = 1'b0;
        check("ignored start done count", 32'(dones), 32'd1);

        // Reset during SCAN
        run_vote("pre-reset", vecs[7].list, 8'd200, 3'd4, 1'b0);
        nb_list    = vecs[0].list;
        vote_start = 1'b1;
        @(posedge clk); #1;
        vote_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst label", 32'(class_label), 32'd0);
        check("midrst count", 32'(vote_count), 32'd0);
        check("midrst no_valid", 32'(no_valid), 32'd0);
        dones = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < K + 2; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("midrst no done", 32'(dones), 32'd0);
        run_vote("post-reset", vecs[0].list, 8'd3, 3'd2, 1'b0);

        // Back-to-back votes with start held high
        b2b_list[0] = vecs[1].list; b2b_lab[0] = 8'd2; b2b_cnt[0] = 3'd2;
        b2b_list[1] = vecs[5].list; b2b_lab[1] = 8'd6; b2b_cnt[1] = 3'd3;
        b2b_list[2] = vecs[3].list; b2b_lab[2] = 8'd5; b2b_cnt[2] = 3'd1;
        nb_list    = b2b_list[0];
        vote_start = 1'b1;
        @(posedge clk); #1;
        nd        = 0;
        last_done = 0;
        prev_done = 1'b0;
        for (int c = 1; c <= 3 * (K + 2) + 2; c++) begin
            @(posedge clk); #1;
            if (prev_done) begin
                check("b2b idle busy", 32'(busy), 32'd0);
                check("b2b idle done", 32'(done), 32'd0);
            end
            prev_done = done;
            if (done && nd < 3) begin
                check("b2b done busy", 32'(busy), 32'd0);
                check("b2b label", 32'(class_label), 32'(b2b_lab[nd]));
                check("b2b count", 32'(vote_count), 32'(b2b_cnt[nd]));
                if (nd == 0) check("b2b first latency", 32'(c), 32'(K));
                else         check("b2b period", 32'(c - last_done), 32'(K + 2));
                last_done = c;
                nd++;
                if (nd < 3) nb_list = b2b_list[nd];
                else        vote_start = 1'b0;
            end
        end
        vote_start = 1'b0;
        check("b2b vote count", 32'(nd), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
